// File: rtl/riscv_defines.sv
// ============================================================================
// Module   : riscv_defines
// Brief    : Shared pipeline types for the hazard/stall controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memaccess_t;

  typedef enum logic {
    HZ_IDLE     = 1'b0,
    HZ_MDU_WAIT = 1'b1
  } hazstate_t;

  // A stage carries a load whose result is not yet forwardable to D.
  function automatic logic is_load_to_reg(input memaccess_t acc,
                                          input logic       regwrite,
                                          input logic [4:0] rd);
    return (acc == MEM_READ) && regwrite && (rd != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_load_use_detector.sv
// ============================================================================
// Module   : hazard_load_use_detector
// Brief    : Combinational load-use interlock detection against E and M1 loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_load_use_detector
  import riscv_defines::*;
(
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        use_rs1_d,
  input  logic        use_rs2_d,
  input  logic        is_store_d,
  input  memaccess_t  memaccess_e,
  input  logic        regwrite_e,
  input  logic [4:0]  rd_e,
  input  memaccess_t  memaccess_m1,
  input  logic        regwrite_m1,
  input  logic [4:0]  rd_m1,
  output logic        ld_stall
);

  logic w_dep1;
  logic w_dep2;
  logic w_store_data;
  logic w_ld_e;
  logic w_ld_m1;
  logic w_hit_e;
  logic w_hit_m1;
  logic w_hit_store;

  assign w_dep1       = use_rs1_d && (rs1_d != 5'd0);
  assign w_dep2       = use_rs2_d && (rs2_d != 5'd0) && !is_store_d;
  assign w_store_data = use_rs2_d && is_store_d;

  assign w_ld_e  = is_load_to_reg(memaccess_e, regwrite_e, rd_e);
  assign w_ld_m1 = is_load_to_reg(memaccess_m1, regwrite_m1, rd_m1);

  assign w_hit_e  = w_ld_e && ((w_dep1 && (rd_e == rs1_d)) || (w_dep2 && (rd_e == rs2_d)));
  assign w_hit_m1 = w_ld_m1 && ((w_dep1 && (rd_m1 == rs1_d)) || (w_dep2 && (rd_m1 == rs2_d)));

  // Store data is only needed at M1, where the W forward covers a load then in M1.
  assign w_hit_store = w_store_data && w_ld_e && (rd_e == rs2_d);

  assign ld_stall = w_hit_e || w_hit_m1 || w_hit_store;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_sequencer.sv
// ============================================================================
// Module   : hazard_stall_sequencer
// Brief    : Pipeline stall/flush controller with MDU handshake and stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_sequencer
  import riscv_defines::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic                 use_rs1_d,
  input  logic                 use_rs2_d,
  input  logic                 is_store_d,
  input  memaccess_t           memaccess_e,
  input  logic                 regwrite_e,
  input  logic [4:0]           rd_e,
  input  memaccess_t           memaccess_m1,
  input  logic                 regwrite_m1,
  input  logic [4:0]           rd_m1,
  input  logic                 mdu_op_e,
  input  logic                 mdu_done,
  input  logic                 branch_taken_e,
  input  logic                 trap_req,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_m1,
  output logic                 mdu_start,
  output logic                 mdu_kill,
  output logic                 mdu_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [7:0] C_TO_LAST = 8'(MDU_TIMEOUT - 1);

  hazstate_t            r_state;
  logic [7:0]           r_to_cnt;
  logic                 r_timeout_flag;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  hazstate_t            w_state_nxt;
  logic [7:0]           w_to_cnt_nxt;
  logic                 w_set_timeout;
  logic                 w_ld_stall;

  hazard_load_use_detector u_load_use (
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .use_rs1_d    (use_rs1_d),
    .use_rs2_d    (use_rs2_d),
    .is_store_d   (is_store_d),
    .memaccess_e  (memaccess_e),
    .regwrite_e   (regwrite_e),
    .rd_e         (rd_e),
    .memaccess_m1 (memaccess_m1),
    .regwrite_m1  (regwrite_m1),
    .rd_m1        (rd_m1),
    .ld_stall     (w_ld_stall)
  );

  always_comb begin
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    flush_m1      = 1'b0;
    mdu_start     = 1'b0;
    mdu_kill      = 1'b0;
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_set_timeout = 1'b0;

    if (rst) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      flush_m1 = 1'b1;
    end else if (trap_req) begin
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m1    = 1'b1;
      mdu_kill    = (r_state == HZ_MDU_WAIT);
      w_state_nxt = HZ_IDLE;
    end else if (branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (r_state == HZ_MDU_WAIT) begin
      if (mdu_done) begin
        w_state_nxt = HZ_IDLE;
      end else if (r_to_cnt == C_TO_LAST) begin
        // Abandoned op leaves E with no valid result, so M1 still gets a bubble.
        mdu_kill      = 1'b1;
        flush_m1      = 1'b1;
        w_set_timeout = 1'b1;
        w_state_nxt   = HZ_IDLE;
      end else begin
        stall_f      = 1'b1;
        stall_d      = 1'b1;
        stall_e      = 1'b1;
        flush_m1     = 1'b1;
        w_to_cnt_nxt = r_to_cnt + 8'd1;
      end
    end else if (mdu_op_e) begin
      mdu_start    = 1'b1;
      stall_f      = 1'b1;
      stall_d      = 1'b1;
      stall_e      = 1'b1;
      flush_m1     = 1'b1;
      w_state_nxt  = HZ_MDU_WAIT;
      w_to_cnt_nxt = 8'd0;
    end else if (w_ld_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= HZ_IDLE;
      r_to_cnt       <= 8'd0;
      r_timeout_flag <= 1'b0;
      r_stall_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      if (w_set_timeout) begin
        r_timeout_flag <= 1'b1;
      end
      if (stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign mdu_timeout  = r_timeout_flag;
  assign stall_cycles = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_sequencer.sv
// ============================================================================
// Module   : tb_hazard_stall_sequencer
// Brief    : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_sequencer;
  import riscv_defines::*;

  localparam int MDU_TO = 8;
  localparam int CW     = 6;
  localparam int CMAX   = (1 << CW) - 1;

  // Output vector bit order: stall_f stall_d stall_e flush_d flush_e flush_m1 mdu_start mdu_kill
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_START = 8'b1110_0110;
  localparam logic [7:0] O_WAIT  = 8'b1110_0100;
  localparam logic [7:0] O_KILL  = 8'b0000_0101;
  localparam logic [7:0] O_BR    = 8'b0001_1000;
  localparam logic [7:0] O_TRAP  = 8'b0001_1100;
  localparam logic [7:0] O_TRAPK = 8'b0001_1101;
  localparam logic [7:0] O_RST   = 8'b0001_1100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rd_e, rd_m1;
  logic use_rs1_d, use_rs2_d, is_store_d;
  memaccess_t memaccess_e, memaccess_m1;
  logic regwrite_e, regwrite_m1, mdu_op_e, mdu_done, branch_taken_e, trap_req;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m1, mdu_start, mdu_kill, mdu_timeout;
  logic [CW-1:0] stall_cycles;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  assign outs = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m1, mdu_start, mdu_kill};

  always #5 clk = ~clk;

  hazard_stall_sequencer #(.MDU_TIMEOUT(MDU_TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .is_store_d(is_store_d),
    .memaccess_e(memaccess_e), .regwrite_e(regwrite_e), .rd_e(rd_e),
    .memaccess_m1(memaccess_m1), .regwrite_m1(regwrite_m1), .rd_m1(rd_m1),
    .mdu_op_e(mdu_op_e), .mdu_done(mdu_done), .branch_taken_e(branch_taken_e),
    .trap_req(trap_req),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m1(flush_m1),
    .mdu_start(mdu_start), .mdu_kill(mdu_kill), .mdu_timeout(mdu_timeout),
    .stall_cycles(stall_cycles)
  );

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0; is_store_d = 0;
    memaccess_e = MEM_NONE; regwrite_e = 0; rd_e = 0;
    memaccess_m1 = MEM_NONE; regwrite_m1 = 0; rd_m1 = 0;
    mdu_op_e = 0; mdu_done = 0; branch_taken_e = 0; trap_req = 0;
  endtask

  task automatic load_in_e(input logic [4:0] rd);
    memaccess_e = MEM_READ; regwrite_e = 1; rd_e = rd;
  endtask

  task automatic load_in_m1(input logic [4:0] rd);
    memaccess_m1 = MEM_READ; regwrite_m1 = 1; rd_m1 = rd;
    memaccess_e = MEM_NONE; regwrite_e = 0; rd_e = 0;
  endtask

  task automatic d_alu(input logic [4:0] a, input logic [4:0] b);
    rs1_d = a; rs2_d = b; use_rs1_d = 1; use_rs2_d = 1; is_store_d = 0;
  endtask

  // Leaves the bench at a negedge, reset deasserted, after one reset edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    use_rs1_d = 1; rs1_d = 5; load_in_e(5); mdu_op_e = 1;
    #1;
    n_checks++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== '0 || mdu_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: stall_cycles=%0d mdu_timeout=%b want 0/0", stall_cycles, mdu_timeout);
    end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_load_use_e();
    do_reset();
    load_in_e(5); d_alu(5, 1);
    #1; n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL lu_e_cycle1: got %b want %b", outs, O_LU); end
    @(negedge clk);
    load_in_m1(5);
    #1; n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL lu_e_cycle2: got %b want %b", outs, O_LU); end
    @(negedge clk);
    memaccess_m1 = MEM_NONE; regwrite_m1 = 0;
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL lu_e_release: got %b want %b", outs, O_NONE); end
    n_checks++;
    if (stall_cycles !== CW'(2)) begin n_fail++; $display("FAIL lu_e_count: got %0d want 2", stall_cycles); end
  endtask

  task automatic test_store_data();
    do_reset();
    load_in_e(5);
    rs1_d = 2; rs2_d = 5; use_rs1_d = 1; use_rs2_d = 1; is_store_d = 1;
    #1; n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL store_e: got %b want %b", outs, O_LU); end
    @(negedge clk);
    load_in_m1(5);
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL store_m1: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    d_alu(1, 5);
    #1; n_checks++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL rs2_m1: got %b want %b", outs, O_LU); end
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== CW'(2)) begin n_fail++; $display("FAIL store_count: got %0d want 2", stall_cycles); end
    clear_inputs();
    rs1_d = 0; use_rs1_d = 1; load_in_e(0);
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL x0_no_stall: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    d_alu(7, 0); load_in_e(7); regwrite_e = 0;
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL nowrite_no_stall: got %b want %b", outs, O_NONE); end
    @(negedge clk);
  endtask

  task automatic test_mdu_done();
    do_reset();
    mdu_op_e = 1;
    #1; n_checks++;
    if (outs !== O_START) begin n_fail++; $display("FAIL mdu_start: got %b want %b", outs, O_START); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1; n_checks++;
      if (outs !== O_WAIT) begin n_fail++; $display("FAIL mdu_wait[%0d]: got %b want %b", i, outs, O_WAIT); end
    end
    @(negedge clk);
    mdu_done = 1;
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL mdu_done: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    mdu_op_e = 0;
    #1; n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL done_in_idle: got %b want %b", outs, O_NONE); end
    n_checks++;
    if (stall_cycles !== CW'(6)) begin n_fail++; $display("FAIL mdu_count: got %0d want 6", stall_cycles); end
    @(negedge clk);
    mdu_done = 0; mdu_op_e = 1;
    #1; n_checks++;
    if (outs !== O_START) begin n_fail++; $display("FAIL mdu_restart: got %b want %b", outs, O_START); end
    @(negedge clk);
  endtask

  task automatic test_mdu_timeout();
    do_reset();
    mdu_op_e = 1;
    @(negedge clk);
    for (int i = 0; i < MDU_TO - 1; i++) begin
      #1; n_checks++;
      if (outs !== O_WAIT) begin n_fail++; $display("FAIL to_wait[%0d]: got %b want %b", i, outs, O_WAIT); end
      @(negedge clk);
    end
    #1; n_checks++;
    if (outs !== O_KILL) begin n_fail++; $display("FAIL to_kill: got %b want %b", outs, O_KILL); end
    @(negedge clk);
    mdu_op_e = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mdu_timeout !== 1'b1 || stall_cycles !== CW'(MDU_TO)) begin
      n_fail++; $display("FAIL to_flag: mdu_timeout=%b stall_cycles=%0d want 1/%0d", mdu_timeout, stall_cycles, MDU_TO);
    end
    do_reset();
    n_checks++;
    if (mdu_timeout !== 1'b0) begin n_fail++; $display("FAIL to_flag_clear: got %b want 0", mdu_timeout); end
  endtask

  task automatic test_branch_trap();
    do_reset();
    load_in_e(5); d_alu(5, 1); branch_taken_e = 1;
    #1; n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL branch_lu: got %b want %b", outs, O_BR); end
    @(negedge clk);
    clear_inputs(); branch_taken_e = 1; mdu_op_e = 1;
    #1; n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL branch_mdu: got %b want %b", outs, O_BR); end
    @(negedge clk);
    branch_taken_e = 0;
    #1; n_checks++;
    if (outs !== O_START) begin n_fail++; $display("FAIL after_branch_start: got %b want %b", outs, O_START); end
    repeat (3) @(negedge clk);
    trap_req = 1;
    #1; n_checks++;
    if (outs !== O_TRAPK) begin n_fail++; $display("FAIL trap_in_wait: got %b want %b", outs, O_TRAPK); end
    @(negedge clk);
    clear_inputs(); load_in_e(9); d_alu(1, 9);
    #1; n_checks++;
    if (outs !== O_LU || mdu_timeout !== 1'b0) begin
      n_fail++; $display("FAIL trap_to_idle: got %b/%b want %b/0", outs, mdu_timeout, O_LU);
    end
    @(negedge clk);
    clear_inputs(); trap_req = 1;
    #1; n_checks++;
    if (outs !== O_TRAP) begin n_fail++; $display("FAIL trap_idle: got %b want %b", outs, O_TRAP); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    load_in_m1(5); d_alu(5, 0);
    repeat (11) @(negedge clk);
    clear_inputs(); mdu_op_e = 1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (stall_cycles !== CW'(17)) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 17", stall_cycles); end
    rst = 1;
    #1; n_checks++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL reset_mid_mdu: got %b want %b", outs, O_RST); end
    @(negedge clk);
    rst = 0; clear_inputs(); load_in_e(3); d_alu(3, 0);
    #1; n_checks++;
    if (stall_cycles !== '0 || outs !== O_LU) begin
      n_fail++; $display("FAIL post_reset: count=%0d outs=%b want 0/%b", stall_cycles, outs, O_LU);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    load_in_e(4); d_alu(4, 4);
    repeat (CMAX + 8) @(negedge clk);
    n_checks++;
    if (stall_cycles !== CW'(CMAX)) begin n_fail++; $display("FAIL saturate: got %0d want %0d", stall_cycles, CMAX); end
  endtask

  function automatic bit e_load_writes(input logic [4:0] r);
    return memaccess_e == MEM_READ && regwrite_e && rd_e == r;
  endfunction

  function automatic bit m1_load_writes(input logic [4:0] r);
    return memaccess_m1 == MEM_READ && regwrite_m1 && rd_m1 == r;
  endfunction

  // An operand must wait if its value comes from a load not yet reachable by forwarding.
  function automatic bit model_load_use();
    bit hit = 0;
    if (use_rs1_d && rs1_d != 0)
      hit = e_load_writes(rs1_d) || m1_load_writes(rs1_d);
    if (use_rs2_d && rs2_d != 0) begin
      if (is_store_d) hit = hit || e_load_writes(rs2_d);
      else            hit = hit || e_load_writes(rs2_d) || m1_load_writes(rs2_d);
    end
    return hit;
  endfunction

  task automatic test_random();
    bit   busy = 0;
    int   spent = 0;
    bit   flag = 0;
    int   cnt = 0;
    logic [7:0] exp;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_checks++;
      if (stall_cycles !== CW'(cnt) || mdu_timeout !== flag) begin
        n_fail++; $display("FAIL rnd_regs cyc %0d: count=%0d flag=%b want %0d/%b", cyc, stall_cycles, mdu_timeout, cnt, flag);
      end
      rst = ($urandom_range(0, 99) == 0);
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      use_rs1_d = 1'($urandom); use_rs2_d = 1'($urandom); is_store_d = 1'($urandom);
      memaccess_e  = memaccess_t'($urandom_range(0, 2)); regwrite_e  = 1'($urandom); rd_e  = 5'($urandom_range(0, 3));
      memaccess_m1 = memaccess_t'($urandom_range(0, 2)); regwrite_m1 = 1'($urandom); rd_m1 = 5'($urandom_range(0, 3));
      mdu_op_e = busy ? 1'b1 : ($urandom_range(0, 9) == 0);
      mdu_done = ($urandom_range(0, 4) == 0);
      trap_req = ($urandom_range(0, 49) == 0);
      branch_taken_e = busy ? 1'b0 : ($urandom_range(0, 19) == 0);
      #1;
      if (rst) begin
        exp = O_RST; busy = 0; spent = 0; flag = 0; cnt = 0;
      end else begin
        if (trap_req) begin
          exp = busy ? O_TRAPK : O_TRAP; busy = 0;
        end else if (branch_taken_e) begin
          exp = O_BR;
        end else if (busy) begin
          if (mdu_done) begin exp = O_NONE; busy = 0; end
          else if (spent == MDU_TO - 1) begin exp = O_KILL; busy = 0; flag = 1; end
          else begin exp = O_WAIT; spent++; end
        end else if (mdu_op_e) begin
          exp = O_START; busy = 1; spent = 0;
        end else begin
          exp = model_load_use() ? O_LU : O_NONE;
        end
        if (exp[7] && cnt < CMAX) cnt++;
      end
      n_checks++;
      if (outs !== exp) begin n_fail++; $display("FAIL rnd_outs cyc %0d: got %b want %b", cyc, outs, exp); end
      @(negedge clk);
    end
    rst = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_load_use_e();
    test_store_data();
    test_mdu_done();
    test_mdu_timeout();
    test_branch_trap();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
